// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
// The control bundle layout matches the decode stage's output fields.
package pipe_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_W  = 5;

   typedef struct packed {
      logic [2:0] alu_ctrl;
      logic       reg_write;
      logic       mem_write;
      logic [1:0] mem_to_reg;
      logic       alu_src;
      logic       vreg_write;
   } ctrl_t;

   localparam int    CTRL_W      = $bits(ctrl_t);
   localparam ctrl_t CTRL_BUBBLE = '0;

   // Occupancy encoded as {main_valid, skid_valid}
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } occ_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload holding register; clear takes priority over load.
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, optional skid entry,
// flush and bubble insertion (control forced to zero whenever the output is invalid).
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_DATA = 3,
   parameter int REG_W    = DEF_REG_W,
   parameter int NUM_REG  = 3,
   parameter int CTRL_W   = pipe_pkg::CTRL_W,
   parameter bit SKID     = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_DATA*DATA_W-1:0] in_data,
   input  logic [NUM_REG*REG_W-1:0]   in_regs,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_DATA*DATA_W-1:0] out_data,
   output logic [NUM_REG*REG_W-1:0]   out_regs,
   output logic [CTRL_W-1:0]          out_ctrl
);

   localparam int DW = NUM_DATA * DATA_W;
   localparam int RW = NUM_REG * REG_W;
   localparam int PW = DW + RW + CTRL_W;

   logic [PW-1:0] in_pl, main_d, main_q, skid_q;
   logic          main_v, skid_v, accept;
   logic          main_load, main_clear, skid_load, skid_clear;
   occ_t          occ;

   assign in_pl  = {in_ctrl, in_regs, in_data};
   assign accept = in_valid & in_ready & ~flush;

   // Flush wins outright: both entries clear and the incoming beat is dropped.
   always_comb begin
      occ        = occ_t'({main_v, skid_v});
      main_d     = in_pl;
      main_load  = 1'b0;
      main_clear = flush;
      skid_load  = 1'b0;
      skid_clear = flush;
      if (!flush) begin
         case (occ)
            ST_EMPTY: main_load = accept;
            ST_ONE: begin
               main_load  = accept & out_ready;
               skid_load  = accept & ~out_ready;
               main_clear = ~accept & out_ready;
            end
            ST_FULL: begin
               main_d     = skid_q;
               main_load  = out_ready;
               skid_clear = out_ready;
            end
            default: ;
         endcase
      end
   end

   pipe_slot #(.W(PW)) u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .valid (main_v),
      .q     (main_q)
   );

   generate
      if (SKID) begin : g_skid
         pipe_slot #(.W(PW)) u_skid (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (skid_load),
            .clear (skid_clear),
            .d     (in_pl),
            .valid (skid_v),
            .q     (skid_q)
         );
         assign in_ready = ~skid_v;
      end else begin : g_no_skid
         assign skid_v   = 1'b0;
         assign skid_q   = '0;
         assign in_ready = out_ready | ~main_v;
      end
   endgenerate

   assign out_valid = main_v;
   assign out_data  = main_q[DW-1:0];
   assign out_regs  = main_q[DW +: RW];
   assign out_ctrl  = main_v ? main_q[DW+RW +: CTRL_W] : CTRL_W'(CTRL_BUBBLE);

endmodule
